mv_ref_fetch_gen: RTL and testbench

- Downstream neighbour of the motion-vector decode stage.
- Accepts one decoded half-pel motion vector pair (horizontal/vertical PMV output) plus the macroblock origin.
- Emits the sequence of reference-frame row fetch requests (linear address, length, half-pel flags) for the prediction-forming stage.
- Clamps fetch windows to picture bounds, so the predictor never reads outside the frame store.

---
 rtl/mv_ref_fetch_gen.sv | 135 +++++++++++++
 tb/tb_mv_ref_fetch_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mv_ref_fetch_gen.sv
// Reference-frame row fetch generator.
// Takes one decoded half-pel motion vector pair plus a macroblock origin. Emits one fetch request
// per reference row, giving the linear address, fetch length and half-pel flags. The fetch window
// is clamped to the picture so the predictor never reads outside the frame store.
module mv_ref_fetch_gen #(
  parameter int PIC_W  = 176,
  parameter int PIC_H  = 144,
  parameter int BLK    = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       mv_x,
  input  logic [31:0]       mv_y,
  input  logic [15:0]       mb_x,
  input  logic [15:0]       mb_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [4:0]        out_len,
  output logic [4:0]        out_row,
  output logic              out_hx,
  output logic              out_hy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StCalc, StEmit, StFin} state_e;

  state_e             state;
  logic signed [31:0] mv_x_q, mv_y_q;
  logic [15:0]        mb_x_q, mb_y_q;
  logic signed [31:0] fy_q, cx_q;
  logic [4:0]         rows_q;

  logic signed [31:0] fx_c, fy_c, cx_c, x_max_c;
  logic signed [31:0] base_fy_c, base_cx_c, y_c, ry_c, addr_c;
  logic [4:0]         len_c, rows_c, row_nxt_c;

  // Window origin and the address of the next beat. In CALC the beat is row 0 from freshly
  // computed values. In EMIT it is the row after the current one, from the stored window.
  always_comb begin
    fx_c    = $signed({16'd0, mb_x_q}) + (mv_x_q >>> 1);
    fy_c    = $signed({16'd0, mb_y_q}) + (mv_y_q >>> 1);
    len_c   = 5'(BLK) + {4'd0, mv_x_q[0]};
    rows_c  = 5'(BLK) + {4'd0, mv_y_q[0]};
    x_max_c = PIC_W - $signed({27'd0, len_c});
    if (fx_c < 0)            cx_c = '0;
    else if (fx_c > x_max_c) cx_c = x_max_c;
    else                     cx_c = fx_c;

    if (state == StCalc) begin
      base_fy_c = fy_c;
      base_cx_c = cx_c;
      row_nxt_c = '0;
    end else begin
      base_fy_c = fy_q;
      base_cx_c = cx_q;
      row_nxt_c = out_row + 5'd1;
    end
    y_c = base_fy_c + $signed({27'd0, row_nxt_c});
    // Rows above the picture read row 0. Rows below it replicate the last row.
    if (y_c < 0)              ry_c = '0;
    else if (y_c > PIC_H - 1) ry_c = PIC_H - 1;
    else                      ry_c = y_c;
    addr_c = ry_c * PIC_W + base_cx_c;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_len   <= '0;
      out_row   <= '0;
      out_hx    <= 1'b0;
      out_hy    <= 1'b0;
      done      <= 1'b0;
      mv_x_q    <= '0;
      mv_y_q    <= '0;
      mb_x_q    <= '0;
      mb_y_q    <= '0;
      fy_q      <= '0;
      cx_q      <= '0;
      rows_q    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            mv_x_q   <= $signed(mv_x);
            mv_y_q   <= $signed(mv_y);
            mb_x_q   <= mb_x;
            mb_y_q   <= mb_y;
            in_ready <= 1'b0;
            state    <= StCalc;
          end
        end
        StCalc: begin
          fy_q      <= fy_c;
          cx_q      <= cx_c;
          rows_q    <= rows_c;
          out_len   <= len_c;
          out_hx    <= mv_x_q[0];
          out_hy    <= mv_y_q[0];
          out_row   <= '0;
          out_addr  <= ADDR_W'(addr_c);
          out_valid <= 1'b1;
          state     <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            if (out_row == rows_q - 5'd1) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= StFin;
            end else begin
              out_row  <= row_nxt_c;
              out_addr <= ADDR_W'(addr_c);
            end
          end
        end
        StFin: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_ref_fetch_gen.sv
// Directed bench for mv_ref_fetch_gen: table of vectors plus stall, reset and back-to-back runs.
module tb_mv_ref_fetch_gen;

  localparam int PIC_W  = 176;
  localparam int PIC_H  = 144;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [31:0]       mv_x, mv_y;
  logic [15:0]       mb_x, mb_y;
  logic              out_valid, out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [4:0]        out_len, out_row;
  logic              out_hx, out_hy, done;

  mv_ref_fetch_gen #(
    .PIC_W(PIC_W), .PIC_H(PIC_H), .BLK(16), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mv_x(mv_x), .mv_y(mv_y), .mb_x(mb_x), .mb_y(mb_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_len(out_len), .out_row(out_row), .out_hx(out_hx), .out_hy(out_hy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mv_x;
    logic [31:0] mv_y;
    logic [15:0] mb_x;
    logic [15:0] mb_y;
    int          hx;
    int          hy;
    int          len;
    int          rows;
    int          fy;
    int          cx;
    int          first;
    int          last;
  } vec_t;

  vec_t vecs [4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_addr(input int fy, input int cx, input int r);
    int ry;
    ry = fy + r;
    if (ry < 0) ry = 0;
    if (ry > PIC_H - 1) ry = PIC_H - 1;
    return ry * PIC_W + cx;
  endfunction

  // Runs one block. Stalls out_ready at stall_beat, optionally resets at rst_beat, and
  // optionally keeps in_valid high with the next vector presented after acceptance.
  task automatic run_vec(input vec_t v, input int stall_beat, input int stall_cyc,
                         input int rst_beat, input bit hold, input vec_t nxt);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    mv_x = v.mv_x; mv_y = v.mv_y; mb_x = v.mb_x; mb_y = v.mb_y;
    @(posedge clk); #1;
    if (hold) begin
      mv_x = nxt.mv_x; mv_y = nxt.mv_y; mb_x = nxt.mb_x; mb_y = nxt.mb_y;
    end else begin
      in_valid = 1'b0;
    end
    chk("calc_in_ready", in_ready, 0);
    chk("calc_out_valid", out_valid, 0);
    @(posedge clk); #1;
    for (int b = 0; b < v.rows; b++) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_row", out_row, b);
      chk("beat_addr", out_addr, model_addr(v.fy, v.cx, b));
      chk("beat_len", out_len, v.len);
      chk("beat_hx", out_hx, v.hx);
      chk("beat_hy", out_hy, v.hy);
      chk("beat_in_ready", in_ready, 0);
      chk("beat_done", done, 0);
      if (b == 0) chk("first_addr", out_addr, v.first);
      if (b == v.rows - 1) chk("last_addr", out_addr, v.last);
      if (b == rst_beat) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_addr", out_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        return;
      end
      if (b == stall_beat) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_cyc; k++) begin
          @(posedge clk); #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_row", out_row, b);
          chk("stall_addr", out_addr, model_addr(v.fy, v.cx, b));
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("fin_valid", out_valid, 0);
    chk("fin_done", done, 1);
    chk("fin_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    //           mv_x   mv_y  mb_x  mb_y  hx hy len rows fy   cx   first  last
    vecs[0] = '{32'd6,  32'd4,  16'd32,  16'd16,  0, 0, 16, 16, 18,  35,  3203,  5843};
    vecs[1] = '{-32'sd3, 32'd3, 16'd0,   16'd16,  1, 1, 17, 17, 17,  0,   2992,  5808};
    vecs[2] = '{32'd0,  32'd20, 16'd0,   16'd128, 0, 0, 16, 16, 138, 0,   24288, 25168};
    vecs[3] = '{32'd9,  -32'sd8, 16'd160, 16'd0,  1, 0, 17, 16, -4,  159, 159,   2095};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mv_x = '0; mv_y = '0; mb_x = '0; mb_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_out_len", out_len, 0);
    chk("reset_out_row", out_row, 0);
    chk("reset_out_hx", out_hx, 0);
    chk("reset_out_hy", out_hy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], -1, 0, -1, 1'b0, vecs[i]);

    // Backpressure at beat 5 for three cycles; beat 5 address is 23*176+35.
    chk("bp_beat5_model", model_addr(vecs[0].fy, vecs[0].cx, 5), 4083);
    run_vec(vecs[0], 5, 3, -1, 1'b0, vecs[0]);

    // Reset during beat 7, then a fresh block starts at row 0.
    run_vec(vecs[0], -1, 0, 7, 1'b0, vecs[0]);
    run_vec(vecs[1], -1, 0, -1, 1'b0, vecs[1]);

    // in_valid held high across two vectors.
    run_vec(vecs[2], -1, 0, -1, 1'b1, vecs[3]);
    run_vec(vecs[3], -1, 0, -1, 1'b0, vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
